// File: rtl/serial_packet_receiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_packet_receiver_pkg
// Purpose : Shared link constants and types for the serial packet link.
//           Sources, routers and this receiver take the frame geometry from
//           here so every node agrees on a single definition.
// Contents: SPR_ADDR_BITS    destination address width (16-node network)
//           SPR_NUM_NODES    number of nodes on the network
//           SPR_PAYLOAD_BITS payload width
//           SPR_FRAME_BITS   data bits per frame (start bit not included)
//           SPR_FIFO_DEPTH   default receive buffer depth
//           rx_state_t       receiver FSM state encoding
//           sat_inc8()       saturating 8-bit increment
// -----------------------------------------------------------------------------
package serial_packet_receiver_pkg;

    localparam int SPR_ADDR_BITS    = 4;
    localparam int SPR_NUM_NODES    = 16;
    localparam int SPR_PAYLOAD_BITS = 8;
    localparam int SPR_FRAME_BITS   = SPR_ADDR_BITS + SPR_PAYLOAD_BITS;
    localparam int SPR_FIFO_DEPTH   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/serial_packet_receiver_packet_fifo.sv
// -----------------------------------------------------------------------------
// packet_fifo
// Purpose : Small synchronous FIFO holding received packets. DEPTH must be a
//           power of two so the read/write pointers wrap naturally.
// Ports   : clk        system clock, rising edge
//           reset      asynchronous active-high reset (empties the FIFO)
//           push       write push_data at the tail (ignored when full)
//           push_data  entry to write
//           pop        drop the head entry (ignored when empty)
//           head_data  current head entry
//           count      number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module packet_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] C_FULL = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && (r_count != C_FULL);
    assign w_do_pop  = pop  && (r_count != '0);

    // Memory is cleared on reset so the head fields read as zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule

// File: rtl/serial_packet_receiver.sv
// -----------------------------------------------------------------------------
// serial_packet_receiver
// Purpose : Receiving end of the 1-bit serial link. Deserialises framed
//           packets (start bit = 1, then address then payload, LSB first,
//           no stop bit) into a packet FIFO and presents the head on a
//           valid/ready interface. Drives busy back to the transmitter and
//           counts received and misrouted packets.
// Ports   : clk             system clock, rising edge
//           reset           asynchronous active-high reset
//           rx_data         serial line in
//           rx_busy         backpressure; transmitter holds off new frames
//           out_valid       FIFO head valid
//           out_ready       consumer accepts head on out_valid && out_ready
//           out_addr        head packet address
//           out_payload     head packet payload
//           pkt_count       packets written into the FIFO (wraps at 2^26)
//           misroute_count  packets whose address != ID (saturates at 255)
//           overrun         sticky; a frame started while rx_busy was high
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a start bit
// ST_SHIFT | shifting in data bits; r_discard marks an overrun frame
// -----------------------------------------------------------------------------
module serial_packet_receiver
    import serial_packet_receiver_pkg::*;
#(
    parameter int ID           = 0,
    parameter int ADDR_BITS    = SPR_ADDR_BITS,
    parameter int PAYLOAD_BITS = SPR_PAYLOAD_BITS,
    parameter int FIFO_DEPTH   = SPR_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_data,
    output logic                    rx_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_BITS-1:0]    out_addr,
    output logic [PAYLOAD_BITS-1:0] out_payload,
    output logic [25:0]             pkt_count,
    output logic [7:0]              misroute_count,
    output logic                    overrun
);

    localparam int N    = ADDR_BITS + PAYLOAD_BITS;
    localparam int CW   = $clog2(N);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]        C_LAST   = CW'(N - 1);
    localparam logic [ADDR_BITS-1:0] C_ID     = ADDR_BITS'(ID);
    localparam logic [CNTW-1:0]      C_FULL   = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0]      C_ALMOST = CNTW'(FIFO_DEPTH - 1);

    rx_state_t            r_state;
    logic [CW-1:0]        r_bit_cnt;
    logic [N-2:0]         r_shift;
    logic                 r_discard;
    logic [25:0]          r_pkt_count;
    logic [7:0]           r_misroute;
    logic                 r_overrun;

    logic [N-1:0]         w_frame;
    logic [ADDR_BITS-1:0] w_addr;
    logic [PAYLOAD_BITS-1:0] w_payload;
    logic                 w_last_bit;
    logic                 w_push;
    logic                 w_pop;
    logic [N-1:0]         w_push_data;
    logic [N-1:0]         w_head;
    logic [CNTW-1:0]      w_fifo_count;

    // Only N-1 bits are stored: on the last-bit edge the final bit is taken
    // straight from the line, so the push happens on that same edge.
    assign w_frame     = {rx_data, r_shift};
    assign w_addr      = w_frame[ADDR_BITS-1:0];
    assign w_payload   = w_frame[N-1:ADDR_BITS];
    assign w_last_bit  = (r_state == ST_SHIFT) && (r_bit_cnt == C_LAST);
    assign w_push      = w_last_bit && !r_discard;
    assign w_pop       = out_valid && out_ready;
    assign w_push_data = {w_addr, w_payload};

    packet_fifo #(
        .WIDTH (N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    // Busy one entry early while a frame is in flight, so any frame that
    // starts with rx_busy low is guaranteed a free slot when it completes.
    assign rx_busy = (w_fifo_count == C_FULL) ||
                     ((w_fifo_count == C_ALMOST) && (r_state == ST_SHIFT));

    assign out_valid      = (w_fifo_count != '0);
    assign out_addr       = w_head[N-1:PAYLOAD_BITS];
    assign out_payload    = w_head[PAYLOAD_BITS-1:0];
    assign pkt_count      = r_pkt_count;
    assign misroute_count = r_misroute;
    assign overrun        = r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_discard   <= 1'b0;
            r_pkt_count <= '0;
            r_misroute  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        // A frame started against backpressure is still
                        // consumed to stay in step with the line, but dropped.
                        r_discard <= rx_busy;
                        if (rx_busy) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_shift   <= {rx_data, r_shift[N-2:1]};
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    if (r_bit_cnt == C_LAST) begin
                        r_state <= ST_IDLE;
                        if (!r_discard) begin
                            r_pkt_count <= r_pkt_count + 26'd1;
                            if (w_addr != C_ID) begin
                                r_misroute <= sat_inc8(r_misroute);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_packet_receiver.md
Name: serial_packet_receiver

Overview:
- Receiving end of the 1-bit serial source link (data + busy pair) used between traffic sources, routers and sinks.
- Deserialises framed packets into a small FIFO and presents them on a parallel valid/ready interface.
- Asserts busy back to the transmitter for flow control.
- Counts received and misrouted packets, so per-node delivery can be checked and throughput measured in network tests.

Parameters:
- ID, 0, node index; packets with address != ID count as misrouted.
- ADDR_BITS, 4, destination address width (equals `SIZE for 16 nodes).
- PAYLOAD_BITS, 8, payload width.
- FIFO_DEPTH, 4, packet buffer entries (power of two, >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  1  serial line from transmitter/router port.
- rx_busy  out  1  backpressure to transmitter; transmitter must not start a frame while it is high.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- out_addr  out  ADDR_BITS  head packet address.
- out_payload  out  PAYLOAD_BITS  head packet payload.
- pkt_count  out  26  packets written into FIFO, wraps at 2^26.
- misroute_count  out  8  packets with addr != ID; saturates at 255.
- overrun  out  1  sticky; frame started while rx_busy was high.

Behaviour:
- Frame format: idle line = 0; start bit = 1; then N = ADDR_BITS+PAYLOAD_BITS data bits, LSB first, address first (bits 0..ADDR_BITS-1), one bit per clk; no stop bit.
- Back-to-back frames allowed: a new start bit may appear in the cycle after the last data bit.
- FSM IDLE: rx_data==1 sampled -> SHIFT with bit counter = 0; else stay.
- FSM SHIFT: shift rx_data into the shift register and increment the counter.
- On the edge sampling bit N-1: push {addr, payload} into the FIFO, increment pkt_count, update misroute_count if addr != ID, then -> IDLE.
- Latency: start bit sampled at edge E0, last bit at edge EN. If the FIFO was empty, out_valid is high in the cycle after EN with the correct fields.
- rx_busy is combinational from registers: (count == FIFO_DEPTH) || (count == FIFO_DEPTH-1 && state == SHIFT). This guarantees every accepted frame has a free slot.
- Start bit seen in IDLE while rx_busy == 1: set overrun, then consume and discard the frame (SHIFT without push). The FIFO is never overwritten.
- Pop on out_valid && out_ready. Simultaneous push and pop leaves count unchanged; push order is preserved.
- out_valid = (count != 0). Output fields come from the head entry and are held stable while out_valid && !out_ready.
- Empty FIFO: out_ready is ignored. Full FIFO: rx_busy = 1.
- Reset, including mid-frame: state IDLE, partial frame discarded, FIFO empty, count 0.
- Reset values: out_valid 0, rx_busy 0, out_addr/out_payload 0, pkt_count 0, misroute_count 0, overrun 0.

Decomposition:
- Shared constants stay in constants_2D.v: `SIZE (address width), `NUM_NODES.
- Add `PAYLOAD_BITS and a frame-length macro there, so sources and this block share one definition.
- One sub-module: packet_fifo, a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, reset, push, push_data, pop, head_data, count.
  - Asynchronous active-high reset; pointer wrap-around via DEPTH power of two.

Test Plan:
- Single frame, ID=5: addr=5, payload=0xA3, out_ready=1 -> out_valid high for exactly one cycle, starting the cycle after the last bit; out_addr=5, out_payload=0xA3; pkt_count=1, misroute_count=0.
- Four back-to-back frames (payloads 0x01..0x04), out_ready=0, DEPTH=4 -> rx_busy rises during the 4th frame and stays high; popping one entry drops rx_busy; pops return 0x01, 0x02, 0x03, 0x04 in order.
- Start bit injected while rx_busy=1 -> overrun=1, FIFO contents and count unchanged, pkt_count unchanged; the next legal frame is received correctly.
- 300 frames with addr=2 to ID=5 -> misroute_count=255 (saturated), pkt_count=300.
- Reset asserted asynchronously after 6 data bits of a frame -> all outputs take reset values immediately; a fresh frame after deassertion is received intact.
- Simultaneous push and pop with count=2, continuous out_ready=1 and continuous traffic -> count stays bounded, no drops, pkt_count equals the number of pops plus the final count.
